// File: rtl/sram_lut_arbiter.sv
// sram_lut_arbiter
//   Owns the single-port sine-table SRAM. During a table load the flash loader
//   has exclusive write access. Once the table is valid, two DDS read ports
//   share the SRAM round-robin, one access per clock. Each read response is
//   steered back to the port that issued it.
// Ports
//   clk, rst        : system clock, synchronous active-low reset
//   ld_active       : loader busy for the whole table load
//   ld_req/addr/wdata, ld_gnt : loader write request and write-performed strobe
//   rX_req/addr, rX_gnt       : read request and address-accepted strobe (X=0,1)
//   rX_valid, rX_data         : registered read response, one pulse per grant
//   sram_wen/addr/wdata, sram_dout : SRAM interface (read latency RD_LAT)
//   table_ready     : table loaded and readers enabled
//   ld_words        : words written by the last/current load (saturating)
module sram_lut_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_active,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          r0_req,
  input  logic [AW-1:0] r0_addr,
  output logic          r0_gnt,
  output logic          r0_valid,
  output logic [DW-1:0] r0_data,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  output logic          r1_gnt,
  output logic          r1_valid,
  output logic [DW-1:0] r1_data,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_dout,
  output logic          table_ready,
  output logic [AW:0]   ld_words
);

  typedef enum logic [1:0] {ST_WAIT, ST_LOAD, ST_RUN} state_t;

  localparam logic [AW:0] WORDS_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] WORDS_ONE = {{AW{1'b0}}, 1'b1};

  state_t state, state_next;
  logic   rr_last;

  // Return tag pipeline: one (valid, port) entry per SRAM latency stage.
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_port;
  logic              ret_valid;
  logic              ret_port;

  assign ret_valid = tag_valid[RD_LAT-1];
  assign ret_port  = tag_port[RD_LAT-1];

  // Next state and grants. Grants follow the current state, so in the cycle
  // where ld_active changes the old state's access rules still apply.
  always_comb begin
    state_next = state;
    ld_gnt     = 1'b0;
    r0_gnt     = 1'b0;
    r1_gnt     = 1'b0;
    case (state)
      ST_WAIT: begin
        if (ld_active) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        ld_gnt = ld_req;
        if (!ld_active) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (r0_req && r1_req) begin
          // Contention: the port that did not win last time goes now.
          r0_gnt = rr_last;
          r1_gnt = !rr_last;
        end else begin
          r0_gnt = r0_req;
          r1_gnt = r1_req;
        end
        if (ld_active) state_next = ST_LOAD;
      end
      default: state_next = ST_WAIT;
    endcase
  end

  // SRAM mux driven from whichever port holds the grant; idle drives zeros.
  always_comb begin
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (ld_gnt) begin
      sram_wen   = 1'b1;
      sram_addr  = ld_addr;
      sram_wdata = ld_wdata;
    end else if (r0_gnt) begin
      sram_addr = r0_addr;
    end else if (r1_gnt) begin
      sram_addr = r1_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_WAIT;
      table_ready <= 1'b0;
      ld_words    <= '0;
      rr_last     <= 1'b1;
      tag_valid   <= '0;
      tag_port    <= '0;
      r0_valid    <= 1'b0;
      r1_valid    <= 1'b0;
      r0_data     <= '0;
      r1_data     <= '0;
    end else begin
      state <= state_next;

      // A reload restarts the word count and withdraws the table.
      if (state == ST_RUN && ld_active) begin
        ld_words    <= '0;
        table_ready <= 1'b0;
      end else if (ld_gnt && ld_words != WORDS_MAX) begin
        ld_words <= ld_words + WORDS_ONE;
      end
      if (state == ST_LOAD && !ld_active) table_ready <= 1'b1;

      if (r0_gnt)      rr_last <= 1'b0;
      else if (r1_gnt) rr_last <= 1'b1;

      tag_valid[0] <= r0_gnt || r1_gnt;
      tag_port[0]  <= r1_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_port[i]  <= tag_port[i-1];
      end

      // Tags keep flowing through a reload, so earlier reads still complete.
      r0_valid <= ret_valid && !ret_port;
      r1_valid <= ret_valid && ret_port;
      if (ret_valid && !ret_port) r0_data <= sram_dout;
      if (ret_valid && ret_port)  r1_data <= sram_dout;
    end
  end

endmodule

// File: tb/tb_sram_lut_arbiter.sv
// tb_sram_lut_arbiter
//   Bench for sram_lut_arbiter with a behavioural SRAM (one-cycle registered
//   read). Arbitration is driven from a vector table; load, stall, reload and
//   reset sequences are hand-written. Read responses are checked against a
//   scoreboard of expected data and latency, filled on every observed grant.
module tb_sram_lut_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic          clk;
  logic          rst;
  logic          ld_active;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          r0_req;
  logic [AW-1:0] r0_addr;
  logic          r0_gnt;
  logic          r0_valid;
  logic [DW-1:0] r0_data;
  logic          r1_req;
  logic [AW-1:0] r1_addr;
  logic          r1_gnt;
  logic          r1_valid;
  logic [DW-1:0] r1_data;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_dout;
  logic          table_ready;
  logic [AW:0]   ld_words;

  sram_lut_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_active(ld_active), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt),
    .r0_valid(r0_valid), .r0_data(r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt),
    .r1_valid(r1_valid), .r1_data(r1_data),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_dout(sram_dout), .table_ready(table_ready), .ld_words(ld_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM, small address space is enough for this bench.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr[7:0]] <= sram_wdata;
    sram_dout <= mem[sram_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference table contents, written by the stimulus as it loads data.
  logic [DW-1:0] ref_mem [0:15];

  typedef struct {
    logic [DW-1:0] data;
    int            gcyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // Scoreboard: responses checked before this cycle's grants are queued.
  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r0_valid) begin
        if (q0.size() == 0) chk("r0_unexpected_valid", 32'(r0_valid), 32'd0);
        else begin
          e0 = q0.pop_front();
          chk("r0_data", 32'(r0_data), 32'(e0.data));
          chk("r0_latency", 32'(cyc - e0.gcyc), 32'(RD_LAT + 1));
          $display("r0 read  data=%h latency=%0d", r0_data, cyc - e0.gcyc);
        end
      end
      if (r1_valid) begin
        if (q1.size() == 0) chk("r1_unexpected_valid", 32'(r1_valid), 32'd0);
        else begin
          e1 = q1.pop_front();
          chk("r1_data", 32'(r1_data), 32'(e1.data));
          chk("r1_latency", 32'(cyc - e1.gcyc), 32'(RD_LAT + 1));
          $display("r1 read  data=%h latency=%0d", r1_data, cyc - e1.gcyc);
        end
      end
      if (r0_gnt) q0.push_back('{ref_mem[r0_addr[3:0]], cyc});
      if (r1_gnt) q1.push_back('{ref_mem[r1_addr[3:0]], cyc});
    end
  end

  typedef struct {
    logic          r0_req;
    logic [AW-1:0] r0_addr;
    logic          r1_req;
    logic [AW-1:0] r1_addr;
    logic          g0;
    logic          g1;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t vecs [12];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    // rr_last is 1 after the first RUN grant (r1), so contention starts with r0.
    vecs[0]  = '{1'b1, 16'd0, 1'b1, 16'd1, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 16'd0, 1'b1, 16'd1, 1'b0, 1'b1, 16'd1};
    vecs[2]  = '{1'b1, 16'd0, 1'b1, 16'd1, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 16'd0, 1'b1, 16'd1, 1'b0, 1'b1, 16'd1};
    vecs[4]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2};
    vecs[6]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
    vecs[8]  = '{1'b1, 16'd3, 1'b1, 16'd0, 1'b0, 1'b1, 16'd0};
    vecs[9]  = '{1'b0, 16'd0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd2};
    vecs[10] = '{1'b1, 16'd0, 1'b1, 16'd1, 1'b1, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};

    rst = 1'b0; ld_active = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    r0_req = 1'b0; r0_addr = '0; r1_req = 1'b0; r1_addr = '0;
    repeat (3) nxt();
    smp();
    chk("rst_table_ready", 32'(table_ready), 32'd0);
    chk("rst_ld_words", 32'(ld_words), 32'd0);
    chk("rst_r0_valid", 32'(r0_valid), 32'd0);
    chk("rst_r1_valid", 32'(r1_valid), 32'd0);
    chk("rst_r0_data", 32'(r0_data), 32'd0);
    chk("rst_sram_wen", 32'(sram_wen), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);

    // WAIT: r1 request and loader request both stalled.
    nxt();
    rst = 1'b1; r1_req = 1'b1; r1_addr = 16'd1;
    smp();
    chk("wait_r1_gnt", 32'(r1_gnt), 32'd0);
    nxt();
    ld_active = 1'b1; ld_req = 1'b1; ld_addr = 16'd0; ld_wdata = 16'h1111;
    smp();
    chk("wait_ld_gnt", 32'(ld_gnt), 32'd0);
    chk("wait_sram_wen", 32'(sram_wen), 32'd0);
    chk("wait_r1_gnt2", 32'(r1_gnt), 32'd0);
    nxt();

    // LOAD: four writes 0..3.
    for (int i = 0; i < 4; i++) begin
      ld_addr  = 16'(i);
      ld_wdata = 16'(16'h1111 * (i + 1));
      smp();
      chk("load_ld_gnt", 32'(ld_gnt), 32'd1);
      chk("load_sram_wen", 32'(sram_wen), 32'd1);
      chk("load_sram_addr", 32'(sram_addr), 32'(i));
      chk("load_sram_wdata", 32'(sram_wdata), 32'(16'h1111 * (i + 1)));
      chk("load_r1_gnt", 32'(r1_gnt), 32'd0);
      chk("load_table_ready", 32'(table_ready), 32'd0);
      ref_mem[i] = 16'(16'h1111 * (i + 1));
      $display("load write addr=%0d data=%h", i, ref_mem[i]);
      nxt();
    end
    ld_req = 1'b0; ld_active = 1'b0;
    smp();
    chk("load_end_ld_words", 32'(ld_words), 32'd4);
    chk("load_end_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("load_end_table_ready", 32'(table_ready), 32'd0);
    nxt();
    smp();
    chk("run_table_ready", 32'(table_ready), 32'd1);
    chk("run_first_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("run_first_addr", 32'(sram_addr), 32'd1);
    chk("run_ld_words", 32'(ld_words), 32'd4);
    nxt();

    // Arbitration table.
    for (int i = 0; i < 12; i++) begin
      r0_req = vecs[i].r0_req; r0_addr = vecs[i].r0_addr;
      r1_req = vecs[i].r1_req; r1_addr = vecs[i].r1_addr;
      smp();
      chk("arb_r0_gnt", 32'(r0_gnt), 32'(vecs[i].g0));
      chk("arb_r1_gnt", 32'(r1_gnt), 32'(vecs[i].g1));
      chk("arb_sram_addr", 32'(sram_addr), 32'(vecs[i].addr));
      chk("arb_sram_wen", 32'(sram_wen), 32'd0);
      $display("vec %0d r0_gnt=%0d r1_gnt=%0d addr=%0d", i, r0_gnt, r1_gnt, sram_addr);
      nxt();
    end
    repeat (4) nxt();
    chk("arb_q0_drained", 32'(q0.size()), 32'd0);
    chk("arb_q1_drained", 32'(q1.size()), 32'd0);
    chk("arb_r0_data_hold", 32'(r0_data), 32'h1111);
    chk("arb_r1_data_hold", 32'(r1_data), 32'h3333);

    // Loader write attempt in RUN is ignored.
    ld_req = 1'b1; ld_addr = 16'd0; ld_wdata = 16'hDEAD;
    smp();
    chk("run_ld_gnt", 32'(ld_gnt), 32'd0);
    chk("run_ld_sram_wen", 32'(sram_wen), 32'd0);
    nxt();
    ld_req = 1'b0; r0_req = 1'b1; r0_addr = 16'd0;
    smp();
    chk("dead_r0_gnt", 32'(r0_gnt), 32'd1);
    nxt();
    r0_req = 1'b0;
    repeat (3) nxt();
    chk("dead_readback", 32'(r0_data), 32'h1111);

    // Reload one cycle after an r0 grant.
    r0_req = 1'b1; r0_addr = 16'd3;
    smp();
    chk("reload_r0_gnt", 32'(r0_gnt), 32'd1);
    nxt();
    r0_req = 1'b0; ld_active = 1'b1;
    smp();
    chk("reload_edge_table_ready", 32'(table_ready), 32'd1);
    nxt();
    r0_req = 1'b1; r0_addr = 16'd1;
    smp();
    chk("reload_r0_stall", 32'(r0_gnt), 32'd0);
    chk("reload_table_ready", 32'(table_ready), 32'd0);
    chk("reload_ld_words", 32'(ld_words), 32'd0);
    chk("reload_inflight_valid", 32'(r0_valid), 32'd1);
    chk("reload_inflight_data", 32'(r0_data), 32'h4444);
    nxt();
    ld_req = 1'b1; ld_addr = 16'd5; ld_wdata = 16'h5555;
    smp();
    chk("reload_ld_gnt", 32'(ld_gnt), 32'd1);
    chk("reload_r0_stall2", 32'(r0_gnt), 32'd0);
    ref_mem[5] = 16'h5555;
    nxt();
    ld_req = 1'b0; ld_active = 1'b0;
    smp();
    chk("reload_ld_words1", 32'(ld_words), 32'd1);
    chk("reload_r0_stall3", 32'(r0_gnt), 32'd0);
    nxt();
    smp();
    chk("reload_run_ready", 32'(table_ready), 32'd1);
    chk("reload_run_r0_gnt", 32'(r0_gnt), 32'd1);
    nxt();
    r0_req = 1'b0;
    repeat (3) nxt();
    chk("reload_q0_drained", 32'(q0.size()), 32'd0);
    chk("reload_q1_drained", 32'(q1.size()), 32'd0);

    // Reset while a read is in flight: no response, data cleared.
    r0_req = 1'b1; r0_addr = 16'd2;
    smp();
    chk("midrst_r0_gnt", 32'(r0_gnt), 32'd1);
    nxt();
    r0_req = 1'b0; rst = 1'b0;
    nxt();
    smp();
    chk("midrst_r0_valid", 32'(r0_valid), 32'd0);
    chk("midrst_r0_data", 32'(r0_data), 32'd0);
    chk("midrst_r1_data", 32'(r1_data), 32'd0);
    chk("midrst_table_ready", 32'(table_ready), 32'd0);
    chk("midrst_ld_words", 32'(ld_words), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
